mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2: the maximum number of accepted requests still awaiting rvalid, legal range 1..8.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock.
REQ-003 rstn input 1, asynchronous active-low reset.
REQ-004 instr_req_i input 1, fetch request.
REQ-005 instr_addr_i input 32, fetch address.
REQ-006 instr_gnt_o output 1, fetch request accepted.
REQ-007 instr_rvalid_o output 1, fetch response valid.
REQ-008 instr_rdata_o output 32, fetch response data.
REQ-009 data_req_i input 1, load/store request.
REQ-010 data_we_i input 1, 1 = store.
REQ-011 data_be_i input 4, byte enables.
REQ-012 data_addr_i input 32, load/store address.
REQ-013 data_wdata_i input 32, store data.
REQ-014 data_gnt_o output 1, load/store request accepted.
REQ-015 data_rvalid_o output 1, load/store response valid.
REQ-016 data_rdata_o output 32, load response data.
REQ-017 mem_req_o output 1, shared memory request.
REQ-018 mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o outputs 1/4/32/32, request attributes of the selected requester.
REQ-019 mem_gnt_i input 1, memory accepts request.
REQ-020 mem_rvalid_i input 1, memory response valid, in order, at least 1 cycle after its grant.
REQ-021 mem_rdata_i input 32, memory response data.

Function
REQ-022 The request path SHALL be combinational (0-cycle latency): mem_req_o = selected requester's req AND outstanding count < MAX_OUTSTANDING.
REQ-023 A handshake SHALL be mem_req_o & mem_gnt_i; the selected requester's gnt_o SHALL equal this handshake, and the other gnt_o SHALL be 0.
REQ-024 For the instr owner, mem_we_o SHALL be 0 and mem_be_o 4'hF; for the data owner, the attributes SHALL pass through from data_*_i.
REQ-025 Lock: if mem_req_o=1 and mem_gnt_i=0 in a cycle, the owner SHALL be registered and kept next cycle regardless of priority; the lock SHALL clear on handshake or when the owner drops its req.
REQ-026 Unlocked selection SHALL use fixed priority data > instr (see REQ-033 for the alternative).
REQ-027 Each handshake SHALL push the owner ID (0 = instr, 1 = data) into an in-order ID FIFO of depth MAX_OUTSTANDING; each mem_rvalid_i SHALL pop the FIFO and assert the head owner's rvalid_o in the same cycle.
REQ-028 mem_rdata_i SHALL drive both instr_rdata_o and data_rdata_o unregistered.
REQ-029 The outstanding counter, $clog2(MAX_OUTSTANDING+1) bits, SHALL behave as follows: push with pop leaves it unchanged; at MAX_OUTSTANDING it suppresses mem_req_o; a simultaneous pop at full SHALL NOT re-enable the request in the same cycle.
REQ-030 mem_rvalid_i with count 0 SHALL be ignored: no rvalid out, and the count stays 0 (no underflow).

Reset
REQ-031 On rstn low, the count SHALL be 0, the FIFO empty, the lock cleared and the round-robin pointer set to data; mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o and data_rvalid_o SHALL be forced 0, and the other outputs follow the inputs.
REQ-032 A reset mid-transaction SHALL discard pending responses; later stray rvalids fall under REQ-030.

Configuration
REQ-033 With macro MEM_ARB_ROUND_ROBIN_EN defined, unlocked selection SHALL favour the requester not granted by the most recent handshake; without the macro, selection SHALL be fixed priority per REQ-026.

Verification
REQ-034 Both reqs asserted, mem_gnt_i=1 every cycle, rvalid 1 cycle later: without the macro data_gnt_o=1 every cycle; with the macro the grants SHALL alternate data, instr, data, instr.
REQ-035 instr_req_i=1 with mem_gnt_i=0 for 3 cycles, then data_req_i=1 in cycle 2: mem_addr_o SHALL stay instr_addr_i until the handshake and data_gnt_o SHALL stay 0.
REQ-036 MAX_OUTSTANDING=2 with 2 handshakes and no rvalid: mem_req_o=0; a single rvalid SHALL raise mem_req_o the next cycle.
REQ-037 Handshakes instr, data, instr followed by 3 rvalids with rdata 0x11, 0x22, 0x33: instr_rvalid_o SHALL be seen with 0x11, then data_rvalid_o with 0x22, then instr_rvalid_o with 0x33.
REQ-038 Reset asserted with 2 outstanding, then 2 stray rvalids: no rvalid_o SHALL assert, the count SHALL stay 0, and a new request SHALL be granted immediately.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto a single memory port with
// request locking, an outstanding-request limit and an in-order response ID FIFO.
// Optional macro MEM_ARB_ROUND_ROBIN_EN replaces fixed data>instr priority with round-robin.
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    // Owner encoding: 0 = instr, 1 = data.
    logic                       owner;
    logic                       sel_req;
    logic                       handshake;
    logic                       pop;
    logic                       lock;
    logic                       lock_owner;
    logic                       lock_live;
    logic [CW-1:0]              count;
    logic [CW-1:0]              wr_idx;
    logic [MAX_OUTSTANDING-1:0] id_fifo;
    logic [MAX_OUTSTANDING-1:0] id_fifo_nxt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr_ptr;  // requester favoured on the next contended unlocked cycle
`endif

    // A stalled request keeps its owner only while that owner still requests.
    assign lock_live = lock && (lock_owner ? data_req_i : instr_req_i);

    always_comb begin
        owner = data_req_i;
        if (lock_live) begin
            owner = lock_owner;
        end else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (data_req_i && instr_req_i) begin
                owner = rr_ptr;
            end
`endif
        end
    end

    assign sel_req   = owner ? data_req_i : instr_req_i;
    assign mem_req_o = rstn && sel_req && (count < MAX_CNT);
    assign handshake = mem_req_o && mem_gnt_i;
    assign pop       = rstn && mem_rvalid_i && (count != '0);

    assign instr_gnt_o = handshake && !owner;
    assign data_gnt_o  = handshake && owner;

    assign mem_we_o    = owner && data_we_i;
    assign mem_be_o    = owner ? data_be_i : 4'hF;
    assign mem_addr_o  = owner ? data_addr_i : instr_addr_i;
    assign mem_wdata_o = owner ? data_wdata_i : '0;

    assign instr_rvalid_o = pop && !id_fifo[0];
    assign data_rvalid_o  = pop && id_fifo[0];
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    // Head of the ID FIFO sits at bit 0; a pop shifts down, a push lands after the last live entry.
    always_comb begin
        id_fifo_nxt = pop ? (id_fifo >> 1) : id_fifo;
        wr_idx      = count - CW'(pop);
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (handshake && (wr_idx == CW'(i))) begin
                id_fifo_nxt[i] = owner;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count      <= '0;
            id_fifo    <= '0;
            lock       <= 1'b0;
            lock_owner <= 1'b0;
        end else begin
            count   <= count + CW'(handshake) - CW'(pop);
            id_fifo <= id_fifo_nxt;
            if (mem_req_o && !mem_gnt_i) begin
                lock       <= 1'b1;
                lock_owner <= owner;
            end else if (handshake || !sel_req) begin
                lock <= 1'b0;
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= 1'b1;
        end else if (handshake) begin
            rr_ptr <= !owner;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for priority, locking, the outstanding limit, ordering and reset.
module tb_mem_port_arbiter;

    localparam int MAXO = 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int total = 0;
    int bad   = 0;
    int cnt   = 0;
    logic [0:0] exp_q[$];  // expected response owner order

    typedef struct {
        logic ir, dr, dwe;
        logic [3:0] dbe;
        logic gnt, rv;
        logic [31:0] rd;
        logic mreq, ig, dg, own, mwe;
        logic [3:0] mbe;
        logic irv, drv;
    } vec_t;

    vec_t tbl[15];

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rstn(rstn),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    function automatic vec_t mk(input logic ir, dr, dwe, input logic [3:0] dbe,
                                input logic gnt, rv, input logic [31:0] rd,
                                input logic mreq, ig, dg, own, mwe, input logic [3:0] mbe,
                                input logic irv, drv);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dwe = dwe; v.dbe = dbe; v.gnt = gnt; v.rv = rv; v.rd = rd;
        v.mreq = mreq; v.ig = ig; v.dg = dg; v.own = own; v.mwe = mwe; v.mbe = mbe;
        v.irv = irv; v.drv = drv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, dr, dwe, input logic [3:0] dbe,
                         input logic gnt, rv, input logic [31:0] rd);
        cnt++;
        instr_req_i  = ir;
        instr_addr_i = 32'h1000_0000 + 32'(cnt) * 4;
        data_req_i   = dr;
        data_we_i    = dwe;
        data_be_i    = dbe;
        data_addr_i  = 32'h2000_0000 + 32'(cnt) * 4;
        data_wdata_i = ~32'(cnt);
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
    endtask

    // One cycle of a hand sequence; response ownership is predicted from exp_q.
    task automatic step(input string tag, input logic ir, dr, gnt, rv, input logic [31:0] rd,
                        input logic e_req, e_ig, e_dg, e_own);
        logic e_irv, e_drv;
        logic [0:0] h;
        drive(ir, dr, 1'b0, 4'hF, gnt, rv, rd);
        e_irv = 1'b0;
        e_drv = 1'b0;
        if (rv && exp_q.size() > 0) begin
            h = exp_q.pop_front();
            e_irv = !h[0];
            e_drv = h[0];
        end
        @(negedge clk);
        chk({tag, " mem_req"}, 32'(mem_req_o), 32'(e_req));
        chk({tag, " instr_gnt"}, 32'(instr_gnt_o), 32'(e_ig));
        chk({tag, " data_gnt"}, 32'(data_gnt_o), 32'(e_dg));
        chk({tag, " instr_rvalid"}, 32'(instr_rvalid_o), 32'(e_irv));
        chk({tag, " data_rvalid"}, 32'(data_rvalid_o), 32'(e_drv));
        chk({tag, " instr_rdata"}, instr_rdata_o, rd);
        chk({tag, " data_rdata"}, data_rdata_o, rd);
        if (e_req) chk({tag, " mem_addr"}, mem_addr_o, e_own ? data_addr_i : instr_addr_i);
        if (e_ig) exp_q.push_back(1'b0);
        if (e_dg) exp_q.push_back(1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic own;
        //            ir dr we be    g  rv rd        req ig dg own we be    irv drv
        tbl[0]  = mk(0, 0, 0, 4'hF, 0, 0, 32'h0,     0, 0, 0, 0, 0, 4'hF, 0, 0);
        tbl[1]  = mk(1, 0, 0, 4'hF, 1, 0, 32'h0,     1, 1, 0, 0, 0, 4'hF, 0, 0);
        tbl[2]  = mk(0, 1, 1, 4'h3, 1, 1, 32'hAA,    1, 0, 1, 1, 1, 4'h3, 1, 0);
        tbl[3]  = mk(0, 1, 0, 4'hC, 1, 0, 32'h0,     1, 0, 1, 1, 0, 4'hC, 0, 0);
        tbl[4]  = mk(1, 1, 0, 4'hF, 1, 1, 32'hBB,    0, 0, 0, 0, 0, 4'hF, 0, 1);
        tbl[5]  = mk(0, 1, 1, 4'h5, 0, 1, 32'hCC,    1, 0, 0, 1, 1, 4'h5, 0, 1);
        tbl[6]  = mk(1, 1, 1, 4'h5, 1, 0, 32'h0,     1, 0, 1, 1, 1, 4'h5, 0, 0);
        tbl[7]  = mk(1, 0, 0, 4'hF, 0, 0, 32'h0,     1, 0, 0, 0, 0, 4'hF, 0, 0);
        tbl[8]  = mk(1, 1, 1, 4'h6, 0, 0, 32'h0,     1, 0, 0, 0, 0, 4'hF, 0, 0);
        tbl[9]  = mk(1, 1, 1, 4'h6, 1, 1, 32'hDD,    1, 1, 0, 0, 0, 4'hF, 0, 1);
        tbl[10] = mk(0, 0, 0, 4'hF, 0, 1, 32'hEE,    0, 0, 0, 0, 0, 4'hF, 1, 0);
        tbl[11] = mk(0, 0, 0, 4'hF, 0, 1, 32'hFF,    0, 0, 0, 0, 0, 4'hF, 0, 0);
        tbl[12] = mk(0, 1, 0, 4'h9, 0, 0, 32'h0,     1, 0, 0, 1, 0, 4'h9, 0, 0);
        tbl[13] = mk(1, 0, 1, 4'h9, 1, 0, 32'h0,     1, 1, 0, 0, 0, 4'hF, 0, 0);
        tbl[14] = mk(0, 0, 0, 4'hF, 0, 1, 32'h12,    0, 0, 0, 0, 0, 4'hF, 1, 0);

        // Reset: handshake/rvalid outputs forced low, attributes follow inputs.
        rstn = 1'b0;
        drive(1, 0, 0, 4'hF, 1, 1, 32'h5A);
        @(negedge clk);
        chk("rst mem_req", 32'(mem_req_o), 32'h0);
        chk("rst instr_gnt", 32'(instr_gnt_o), 32'h0);
        chk("rst data_gnt", 32'(data_gnt_o), 32'h0);
        chk("rst instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        chk("rst data_rvalid", 32'(data_rvalid_o), 32'h0);
        chk("rst mem_addr", mem_addr_o, instr_addr_i);
        chk("rst instr_rdata", instr_rdata_o, 32'h5A);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            v = tbl[i];
            drive(v.ir, v.dr, v.dwe, v.dbe, v.gnt, v.rv, v.rd);
            @(negedge clk);
            chk($sformatf("v%0d mem_req", i), 32'(mem_req_o), 32'(v.mreq));
            chk($sformatf("v%0d instr_gnt", i), 32'(instr_gnt_o), 32'(v.ig));
            chk($sformatf("v%0d data_gnt", i), 32'(data_gnt_o), 32'(v.dg));
            chk($sformatf("v%0d instr_rvalid", i), 32'(instr_rvalid_o), 32'(v.irv));
            chk($sformatf("v%0d data_rvalid", i), 32'(data_rvalid_o), 32'(v.drv));
            chk($sformatf("v%0d instr_rdata", i), instr_rdata_o, v.rd);
            chk($sformatf("v%0d data_rdata", i), data_rdata_o, v.rd);
            if (v.mreq) begin
                chk($sformatf("v%0d mem_addr", i), mem_addr_o, v.own ? data_addr_i : instr_addr_i);
                chk($sformatf("v%0d mem_we", i), 32'(mem_we_o), 32'(v.mwe));
                chk($sformatf("v%0d mem_be", i), 32'(mem_be_o), 32'(v.mbe));
                if (v.own) chk($sformatf("v%0d mem_wdata", i), mem_wdata_o, data_wdata_i);
            end
            @(posedge clk);
            #1;
        end

        // Both requesting, grant every cycle, responses one cycle later.
        for (int k = 0; k < 4; k++) begin
            own = RR ? (k % 2 == 0) : 1'b1;
            step($sformatf("prio%0d", k), 1, 1, 1, k > 0, 32'h100 + 32'(k), 1, !own, own, own);
        end
        step("prio drain", 0, 0, 0, 1, 32'h104, 0, 0, 0, 0);

        // Stalled instr request stays owner even after data arrives.
        step("lock0", 1, 0, 0, 0, 32'h0, 1, 0, 0, 0);
        step("lock1", 1, 1, 0, 0, 32'h0, 1, 0, 0, 0);
        step("lock2", 1, 1, 0, 0, 32'h0, 1, 0, 0, 0);
        step("lock3", 1, 1, 1, 0, 32'h0, 1, 1, 0, 0);
        step("lock4", 0, 1, 1, 1, 32'hAB, 1, 0, 1, 1);
        step("lock5", 0, 0, 0, 1, 32'hAC, 0, 0, 0, 0);

        // Outstanding limit: pop at full does not re-enable in the same cycle.
        step("full0", 1, 0, 1, 0, 32'h0, 1, 1, 0, 0);
        step("full1", 1, 0, 1, 0, 32'h0, 1, 1, 0, 0);
        step("full2", 1, 0, 1, 0, 32'h0, 0, 0, 0, 0);
        step("full3", 1, 0, 1, 1, 32'h55, 0, 0, 0, 0);
        step("full4", 1, 0, 1, 0, 32'h0, 1, 1, 0, 0);
        step("full5", 0, 0, 0, 1, 32'h56, 0, 0, 0, 0);
        step("full6", 0, 0, 0, 1, 32'h57, 0, 0, 0, 0);

        // In-order responses: instr 0x11, data 0x22, instr 0x33.
        step("ord0", 1, 0, 1, 0, 32'h0, 1, 1, 0, 0);
        step("ord1", 0, 1, 1, 0, 32'h0, 1, 0, 1, 1);
        step("ord2", 1, 0, 1, 1, 32'h11, 0, 0, 0, 0);
        step("ord3", 1, 0, 1, 0, 32'h0, 1, 1, 0, 0);
        step("ord4", 0, 0, 0, 1, 32'h22, 0, 0, 0, 0);
        step("ord5", 0, 0, 0, 1, 32'h33, 0, 0, 0, 0);

        // Reset with two outstanding, then stray responses are ignored.
        step("mid0", 1, 0, 1, 0, 32'h0, 1, 1, 0, 0);
        step("mid1", 0, 1, 1, 0, 32'h0, 1, 0, 1, 1);
        drive(1, 0, 0, 4'hF, 1, 1, 32'h77);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid rst mem_req", 32'(mem_req_o), 32'h0);
        chk("mid rst instr_gnt", 32'(instr_gnt_o), 32'h0);
        chk("mid rst instr_rvalid", 32'(instr_rvalid_o), 32'h0);
        chk("mid rst data_rvalid", 32'(data_rvalid_o), 32'h0);
        chk("mid rst mem_addr", mem_addr_o, instr_addr_i);
        exp_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step("stray0", 0, 0, 0, 1, 32'h78, 0, 0, 0, 0);
        step("stray1", 0, 0, 0, 1, 32'h79, 0, 0, 0, 0);
        step("post0", 1, 0, 1, 0, 32'h0, 1, 1, 0, 0);
        step("post1", 0, 1, 1, 0, 32'h0, 1, 0, 1, 1);
        step("post2", 1, 0, 1, 0, 32'h0, 0, 0, 0, 0);
        step("post3", 0, 0, 0, 1, 32'h7A, 0, 0, 0, 0);
        step("post4", 0, 0, 0, 1, 32'h7B, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
